// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and signed/unsigned mode.
// Define BOOTH_ZERO_SKIP_EN to finish in one cycle when either operand is zero.
module booth_mult_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state;
  logic [XW-1:0]   a_q, q_q, m_q;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;

  logic [XW-1:0]   m_ext, q_ext, a_sum, a_nxt, q_nxt;
  logic            qm1_nxt;
  logic            zero_op;

  // Operand extension to WIDTH+1 bits: sign copy in signed mode, zero fill otherwise.
  always_comb begin
    m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};
  end

`ifdef BOOTH_ZERO_SKIP_EN
  assign zero_op = (m_ext == '0) || (q_ext == '0);
`else
  assign zero_op = 1'b0;
`endif

  // One Booth step: conditional add/subtract, then arithmetic shift of {A, Q, Q(-1)}.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    {a_nxt, q_nxt, qm1_nxt} = {a_sum[XW-1], a_sum, q_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A zeroed datapath with a single pass yields a zero product in one step.
            m_q   <= zero_op ? '0 : m_ext;
            q_q   <= zero_op ? '0 : q_ext;
            a_q   <= '0;
            qm1_q <= 1'b0;
            cnt_q <= zero_op ? CW'(1) : CW'(XW);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_nxt;
          q_q   <= q_nxt;
          qm1_q <= qm1_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            product <= {a_nxt[WIDTH-2:0], q_nxt};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Self-checking bench for booth_mult_param: cycle model at WIDTH=8 plus sweeps at WIDTH=4 and 16.
module tb_booth_mult_param;

`ifdef BOOTH_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  booth_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .product(prod8), .busy(busy8), .done(done8));
  booth_mult_param #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .multiplicand(a4), .multiplier(b4), .product(prod4), .busy(busy4), .done(done4));
  booth_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .product(prod16), .busy(busy16), .done(done16));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference product: interpret operands per mode, multiply, keep the low 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int w);
    longint x, y, msk;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    msk = (longint'(1) << (2 * w)) - 1;
    return 64'($unsigned((x * y) & msk));
  endfunction

  // Cycle model of the WIDTH=8 unit: one op at a time, fixed latency, product from arithmetic.
  logic        m_busy, m_done;
  logic [15:0] m_prod, m_pend;
  int          m_left;
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_pend <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start8) begin
          m_busy <= 1'b1;
          m_pend <= 16'(ref_mul(64'(a8), 64'(b8), sm8, 8));
          m_left <= (ZSKIP && (a8 == 8'h00 || b8 == 8'h00)) ? 1 : 9;
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model busy", 64'(busy8), 64'(m_busy));
      chk("model done", 64'(done8), 64'(m_done));
      chk("model product", 64'(prod8), 64'(m_prod));
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                     input logic [15:0] exp, input int lat);
    int cycles;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = s;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (!done8 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    chk($sformatf("lat8 %h*%h s%0d", a, b, s), 64'(cycles), 64'(lat));
    chk($sformatf("prod8 %h*%h s%0d", a, b, s), 64'(prod8), 64'(exp));
  endtask

  initial begin
    int cycles;
    int ndone;
    logic [15:0] exp;
    reset = 1'b1;
    start8 = 0; sm8 = 0; a8 = '0; b8 = '0;
    start4 = 0; sm4 = 0; a4 = '0; b4 = '0;
    start16 = 0; sm16 = 0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy8), 64'd0);
    chk("reset done", 64'(done8), 64'd0);
    chk("reset product", 64'(prod8), 64'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    op8(8'hFB, 8'hF9, 1'b1, 16'h0023, 9);
    op8(8'h7F, 8'h80, 1'b1, 16'hC080, 9);
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 9);
    op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, 9);
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 9);
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 9);
    op8(8'h00, 8'h5A, 1'b0, 16'h0000, ZSKIP ? 1 : 9);

    // Start pulsed mid-operation is ignored; start in the done cycle is taken at once.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h03; b8 = 8'h05; sm8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    repeat (3) begin @(negedge clk); cycles++; end
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    @(negedge clk);
    cycles++;
    start8 = 1'b0;
    while (!done8 && cycles < 50) begin @(negedge clk); cycles++; end
    chk("busy-start lat", 64'(cycles), 64'd9);
    chk("busy-start prod", 64'(prod8), 64'h000F);
    start8 = 1'b1; a8 = 8'h0C; b8 = 8'h0D; sm8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 1;
    while (!done8 && cycles < 50) begin @(negedge clk); cycles++; end
    chk("b2b done spacing", 64'(cycles), 64'd10);
    chk("b2b prod", 64'(prod8), 64'h009C);

    // Reset four cycles into an operation aborts it without a done pulse.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 64'(busy8), 64'd0);
    chk("abort done", 64'(done8), 64'd0);
    chk("abort product", 64'(prod8), 64'd0);
    ndone = 0;
    repeat (12) begin @(negedge clk); if (done8) ndone++; end
    chk("abort no done", 64'(ndone), 64'd0);
    op8(8'h12, 8'h34, 1'b0, 16'h03A8, 9);

    // Random sweep at WIDTH=4.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      start4 = 1'b1;
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      sm4 = 1'($urandom_range(0, 1));
      @(negedge clk);
      start4 = 1'b0;
      cycles = 0;
      while (!done4 && cycles < 50) begin @(negedge clk); cycles++; end
      chk($sformatf("lat4 %h*%h s%0d", a4, b4, sm4), 64'(cycles),
          64'((ZSKIP && (a4 == 4'h0 || b4 == 4'h0)) ? 1 : 5));
      chk($sformatf("prod4 %h*%h s%0d", a4, b4, sm4), 64'(prod4),
          ref_mul(64'(a4), 64'(b4), sm4, 4));
    end

    // Random sweep at WIDTH=16, led by the most negative square.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start16 = 1'b1;
      a16 = (i == 0) ? 16'h8000 : 16'($urandom);
      b16 = (i == 0) ? 16'h8000 : 16'($urandom);
      sm16 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      start16 = 1'b0;
      cycles = 0;
      while (!done16 && cycles < 60) begin @(negedge clk); cycles++; end
      chk($sformatf("lat16 %h*%h s%0d", a16, b16, sm16), 64'(cycles),
          64'((ZSKIP && (a16 == 16'h0 || b16 == 16'h0)) ? 1 : 17));
      if (i == 0) chk("prod16 8000^2", 64'(prod16), 64'h4000_0000);
      chk($sformatf("prod16 %h*%h s%0d", a16, b16, sm16), 64'(prod16),
          ref_mul(64'(a16), 64'(b16), sm16, 16));
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_param.md
Name: booth_mult_param

Overview:
Parametrised sequential radix-2 Booth multiplier. It is the next generation of the team's fixed 4-bit reset-started Booth unit. Adds configurable operand width, a start/busy/done handshake (no reset needed per operation), and run-time signed/unsigned mode. Sits as a multicycle arithmetic unit behind a simple controller that issues one multiply at a time.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock, the block's only clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
multiplicand  input  WIDTH  operand A; sampled with start
multiplier  input  WIDTH  operand B; sampled with start
product  output  2*WIDTH  result; registered, held until the next result or reset
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, high in the cycle product first shows the new result

Behaviour:
- Reset: sampled on a clk rising edge while reset=1. Forces state IDLE, product=0, busy=0, done=0, and clears all internal registers. Reset wins over every other input and aborts any operation in progress; no done pulse for the aborted operation.
- Internal datapath: each operand is extended to WIDTH+1 bits. In signed mode the extension copies the MSB; in unsigned mode it is zero-filled. Accumulator A is WIDTH+1 bits, Q is WIDTH+1 bits, plus Q(-1). Iteration count = WIDTH+1.
- Per iteration, decide on {Q[0], Q(-1)}: 01 -> A = A + M; 10 -> A = A - M; 00/11 -> no add. Then arithmetic-shift-right {A, Q, Q(-1)} by 1. Arithmetic is modulo 2^(WIDTH+1) and intermediate overflow is discarded.
- Result = low 2*WIDTH bits of {A, Q}. This is exact for both modes; there is no overflow case.
- FSM states:
  - IDLE: busy=0. At an edge with start=1, latch operands and mode, clear A, Q(-1)=0, counter=WIDTH+1, go CALC. start=0 stays in IDLE.
  - CALC: busy=1. One iteration per edge; counter decrements. At the edge performing the last iteration, register product and set done=1 for one cycle, then go IDLE.
- Timing, with E0 = the edge sampling start:
  - Iterations occur at E1..E(WIDTH+1).
  - busy is high from after E0 until E(WIDTH+1).
  - done and the new product are visible from E(WIDTH+1) to E(WIDTH+2).
  - Latency is WIDTH+1 cycles. Back-to-back throughput is one result per WIDTH+2 cycles.
- start while busy=1 is ignored and not queued. Input changes during CALC have no effect.
- start asserted in the done cycle is accepted at E(WIDTH+2), because the FSM is already in IDLE.
- done never asserts without a preceding accepted start.

Optional Feature:
BOOTH_ZERO_SKIP_EN:
- Defined: if the extended multiplicand or multiplier is zero at acceptance, the FSM goes straight to a result at E1: product=0, done=1 in the cycle after E1, busy high only between E0 and E1.
- Undefined: zero operands take the full WIDTH+1 iterations like any other.
- The product value is identical in both builds; only latency differs.

Test Plan:
- WIDTH=8, signed_mode=1, A=0xFB (-5), B=0xF9 (-7), start one cycle -> done pulse 9 cycles after E0, product=0x0023, busy high for exactly 9 cycles.
- WIDTH=8, signed: 0x7F x 0x80 -> 0xC080; 0x80 x 0x80 -> 0x4000; 0xFF x 0x01 -> 0xFFFF.
- WIDTH=8, signed_mode=0: 0xFF x 0xFF -> 0xFE01; the same operands with signed_mode=1 -> 0x0001.
- Handshake: pulse start during CALC with different operands -> ignored, result unchanged. Then assert start in the done cycle -> second operation accepted with no idle gap, second done exactly 10 cycles after the first.
- Reset mid-CALC (cycle 4): next cycle busy=0, done=0, product=0, no done pulse. A following start runs normally to the correct product.
- Zero operand (0x00 x 0x5A): with BOOTH_ZERO_SKIP_EN, done appears 1 cycle after E0 with product=0. Without it, done appears after 9 cycles with product=0. Also run one random-vector sweep at WIDTH=4 and WIDTH=16 against a reference model.
